// File: rtl/proc_pkg.sv
// Shared opcodes, field positions and FSM state encoding for proc_multicycle.
package proc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_OUT = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_BNE = 3'd6;
  localparam logic [2:0] OP_MOV = 3'd7;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 13;
  localparam int RD_HI  = 12;
  localparam int RD_LO  = 10;
  localparam int RS_HI  = 9;
  localparam int RS_LO  = 7;
  localparam int IMM_HI = 9;
  localparam int IMM_LO = 0;

  localparam logic [15:0] HALT_INSN = 16'hE380;

  typedef enum logic [2:0] {
    FETCH,
    EXEC,
    WB,
    OUT,
    HALT
  } state_t;

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU; non-arithmetic opcodes pass operand b through.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = b;
    unique case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/proc_multicycle.sv
// Multicycle core: FETCH/EXEC/WB/OUT FSM, PC, 8-entry regfile, valid/ready output.
// Define PROC_HALT_EN to make 16'hE380 stop the core in HALT.
module proc_multicycle
  import proc_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IMEM_DEPTH = 64,
  parameter int RESET_PC   = 0,
  localparam int PC_W      = $clog2(IMEM_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              retire,
  output logic              halted
);

  state_t            state;
  logic [PC_W-1:0]   pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] result;
  logic              taken;

  logic [2:0]        op;
  logic [2:0]        rd;
  logic [2:0]        rs;
  logic [2:0]        f_op;
  logic [2:0]        f_rd;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_y;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   pc_next;

  assign op      = ir[OP_HI:OP_LO];
  assign rd      = ir[RD_HI:RD_LO];
  assign rs      = ir[RS_HI:RS_LO];
  assign f_op    = imem_data[OP_HI:OP_LO];
  assign f_rd    = imem_data[RD_HI:RD_LO];
  assign imm_ext = DATA_W'(ir[IMM_HI:IMM_LO]);
  assign rd_val  = regs[rd];
  assign rs_val  = regs[rs];
  assign alu_b   = (op == OP_LDI) ? imm_ext : rs_val;

  // Power-of-two depth: the natural PC_W overflow is the wrap to 0.
  assign pc_inc  = pc + PC_W'(1);
  assign pc_next = (op == OP_BNE && taken) ? ir[PC_W-1:0] : pc_inc;

  assign imem_addr = pc;

  proc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a (rd_val),
    .b (alu_b),
    .op(op),
    .y (alu_y)
  );

`ifdef PROC_HALT_EN
  logic halt_q;
  assign halted = halt_q;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= PC_W'(RESET_PC);
      ir        <= '0;
      result    <= '0;
      taken     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      retire    <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
`ifdef PROC_HALT_EN
      halt_q    <= 1'b0;
`endif
    end else begin
      retire <= 1'b0;
      unique case (state)
        FETCH: begin
          ir <= imem_data;
          if (f_op == OP_OUT) begin
            out_data  <= regs[f_rd];
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          result <= alu_y;
          taken  <= (rd_val != '0);
          state  <= WB;
        end
        WB: begin
          if (op != OP_BNE) regs[rd] <= result;
          retire <= 1'b1;
`ifdef PROC_HALT_EN
          if (ir == HALT_INSN) begin
            halt_q <= 1'b1;
            state  <= HALT;
          end else begin
            pc    <= pc_next;
            state <= FETCH;
          end
`else
          pc    <= pc_next;
          state <= FETCH;
`endif
        end
        OUT: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            pc        <= pc_inc;
            retire    <= 1'b1;
            state     <= FETCH;
          end
        end
`ifdef PROC_HALT_EN
        HALT: state <= HALT;
`endif
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_proc_multicycle.sv
// Directed bench: ISA-level model vs 16- and 24-bit instances on shared imem.
module tb_proc_multicycle;

  localparam int DEPTH = 64;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [15:0] mem [DEPTH];
  logic [5:0]  a16, a24;
  logic [15:0] d16, d24;
  logic [15:0] o16;
  logic [23:0] o24;
  logic        v16, v24, rt16, rt24, h16, h24;
  logic        out_ready = 1'b0;

  assign d16 = mem[a16];
  assign d24 = mem[a24];

  proc_multicycle #(.DATA_W(16), .IMEM_DEPTH(DEPTH), .RESET_PC(0)) dut16 (
    .clock(clock), .reset(reset), .imem_addr(a16), .imem_data(d16),
    .out_data(o16), .out_valid(v16), .out_ready(out_ready),
    .retire(rt16), .halted(h16)
  );

  proc_multicycle #(.DATA_W(24), .IMEM_DEPTH(DEPTH), .RESET_PC(0)) dut24 (
    .clock(clock), .reset(reset), .imem_addr(a24), .imem_data(d24),
    .out_data(o24), .out_valid(v24), .out_ready(out_ready),
    .retire(rt24), .halted(h24)
  );

  int vec = 0;
  int err = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ISA-level reference: runs n instructions from address 0
  int unsigned expq[$];
  int          m_pc, m_cyc, m_halt;

  task automatic model_run(input int n);
    int unsigned r[8];
    int pc, op, rd, rs, imm;
    logic [15:0] ins;
    for (int i = 0; i < 8; i++) r[i] = 0;
    pc = 0;
    m_cyc = 0;
    m_halt = 0;
    for (int i = 0; i < n; i++) begin
      ins = mem[pc];
      op  = int'(ins[15:13]);
      rd  = int'(ins[12:10]);
      rs  = int'(ins[9:7]);
      imm = int'(ins[9:0]);
`ifdef PROC_HALT_EN
      if (ins == 16'hE380) begin
        m_halt = 1;
        m_cyc += 3;
        break;
      end
`endif
      if (op == 4) begin
        expq.push_back(r[rd]);
        m_cyc += 2;
        pc = (pc + 1) % DEPTH;
      end else begin
        m_cyc += 3;
        case (op)
          0: r[rd] = r[rd] + r[rs];
          1: r[rd] = r[rd] - r[rs];
          2: r[rd] = r[rd] & r[rs];
          3: r[rd] = r[rd] | r[rs];
          5: r[rd] = imm;
          7: r[rd] = r[rs];
          default: ;
        endcase
        if (op == 6 && r[rd] != 0) pc = imm % DEPTH;
        else pc = (pc + 1) % DEPTH;
      end
    end
    m_pc = pc;
  endtask

  // Compare process: every negedge, decides ready for the next edge
  int           stall_cfg = 0;
  int           stall_left = 0;
  int           rc[2];
  int           ptr[2];
  bit           hv[2], px[2];
  logic [23:0]  held[2];
  logic [23:0]  lastd[2];
  logic [23:0]  od[2];
  bit           ov[2];
  bit           rdy;
  int           low_cnt = 0;
  int unsigned  mask[2] = '{32'h0000FFFF, 32'h00FFFFFF};

  always @(negedge clock) begin
    if (reset) begin
      rc = '{0, 0};
      ptr = '{0, 0};
      hv = '{0, 0};
      px = '{0, 0};
      low_cnt = 0;
      stall_left = stall_cfg;
      out_ready = (stall_cfg == 0);
    end else begin
      od[0] = {8'h00, o16};
      od[1] = o24;
      ov[0] = v16;
      ov[1] = v24;
      if (rt16) rc[0]++;
      if (rt24) rc[1]++;
      rdy = (stall_left == 0);
      out_ready = rdy;
      for (int k = 0; k < 2; k++) begin
        if (px[k]) check("valid_drop", 64'(ov[k]), 64'd0);
        px[k] = 0;
        if (ov[k]) begin
          if (hv[k]) check("hold", 64'(od[k]), 64'(held[k]));
          if (rdy) begin
            if (ptr[k] < expq.size())
              check("out_data", 64'(od[k]), 64'(expq[ptr[k]] & mask[k]));
            else
              check("extra_xfer", 64'(ptr[k]), 64'(expq.size()));
            lastd[k] = od[k];
            ptr[k]++;
            hv[k] = 0;
            px[k] = 1;
          end else begin
            held[k] = od[k];
            hv[k] = 1;
            if (k == 0) low_cnt++;
          end
        end
      end
      if (v16 && stall_left > 0) stall_left--;
    end
  end

  task automatic run(input int n, input int stall, output int cyc);
    reset = 1'b1;
    stall_cfg = stall;
    expq.delete();
    model_run(n);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    cyc = 0;
    while (1) begin
      @(posedge clock);
      cyc++;
      #6;
      if (rc[0] >= n) break;
      if (cyc > 3000) begin
        check("timeout", 64'(rc[0]), 64'(n));
        break;
      end
    end
    check("retire16", 64'(rc[0]), 64'(n));
    check("retire24", 64'(rc[1]), 64'(n));
    check("pc16", 64'(a16), 64'(m_pc));
    check("pc24", 64'(a24), 64'(m_pc));
    check("nout16", 64'(ptr[0]), 64'(expq.size()));
    check("nout24", 64'(ptr[1]), 64'(expq.size()));
    check("halted", 64'(h16), 64'(m_halt));
    if (stall == 0) check("cycles", 64'(cyc), 64'(m_cyc));
  endtask

  task automatic fill();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'hA000;
  endtask

  int c;

  initial begin
    fill();
    #12;
    check("rst_valid", 64'(v16), 64'd0);
    check("rst_data", 64'(o16), 64'd0);
    check("rst_retire", 64'(rt16), 64'd0);
    check("rst_halted", 64'(h16), 64'd0);
    check("rst_pc", 64'(a16), 64'd0);

    // LDI R1,5; LDI R2,3; ADD R1,R2; OUT R1
    fill();
    mem[0] = 16'hA405; mem[1] = 16'hA803;
    mem[2] = 16'h0500; mem[3] = 16'h8400;
    run(4, 0, c);
    check("t1_cycles", 64'(c), 64'd11);
    check("t1_out16", 64'(lastd[0]), 64'd8);
    check("t1_out24", 64'(lastd[1]), 64'd8);

    // LDI R0,0; LDI R3,1; SUB R0,R3; OUT R0
    fill();
    mem[0] = 16'hA000; mem[1] = 16'hAC01;
    mem[2] = 16'h2180; mem[3] = 16'h8000;
    run(4, 0, c);
    check("t2_out16", 64'(lastd[0]), 64'h0000FFFF);
    check("t2_out24", 64'(lastd[1]), 64'h00FFFFFF);

    // countdown; BNE target 0x042 truncates to 2
    fill();
    mem[0] = 16'hA403; mem[1] = 16'hA801; mem[2] = 16'h8400;
    mem[3] = 16'h2500; mem[4] = 16'hC442;
    run(11, 0, c);
    check("t3_m0", 64'(expq[0]), 64'd3);
    check("t3_m1", 64'(expq[1]), 64'd2);
    check("t3_m2", 64'(expq[2]), 64'd1);
    check("t3_pc", 64'(a16), 64'd5);
    check("t3_cycles", 64'(c), 64'd30);
    check("t3_last", 64'(lastd[0]), 64'd1);

    // backpressure: 4 ready-low cycles
    fill();
    mem[0] = 16'hB02A; mem[1] = 16'h9000;
    run(2, 4, c);
    check("t4_low", 64'(low_cnt), 64'd4);
    check("t4_out", 64'(lastd[0]), 64'h2A);
    check("t4_cycles", 64'(c), 64'd9);

    // reset while out_valid is high
    fill();
    mem[0] = 16'hB407; mem[1] = 16'h9400;
    reset = 1'b1;
    stall_cfg = 1000;
    expq.delete();
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    c = 0;
    while (!v16 && c < 100) begin
      @(posedge clock);
      #1 c++;
    end
    check("t5_saw_valid", 64'(v16), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t5_valid16", 64'(v16), 64'd0);
    check("t5_valid24", 64'(v24), 64'd0);
    check("t5_pc", 64'(a16), 64'd0);
    check("t5_data", 64'(o16), 64'd0);
    mem[0] = 16'h9400;
    run(1, 0, c);
    check("t5_reg0", 64'(lastd[0]), 64'd0);

    // pc wrap 63 -> 0
    fill();
    mem[0] = 16'hA401; mem[1] = 16'hC43F; mem[63] = 16'hA805;
    run(3, 0, c);
    check("t6_wrap", 64'(a16), 64'd0);

    // halt instruction
    fill();
    mem[0] = 16'hA409; mem[1] = 16'hE380; mem[2] = 16'h8400;
`ifdef PROC_HALT_EN
    run(2, 0, c);
    repeat (20) @(posedge clock);
    #1;
    check("t7_halted", 64'(h16), 64'd1);
    check("t7_pc", 64'(a16), 64'd1);
    check("t7_retire", 64'(rc[0]), 64'd2);
`else
    run(2, 0, c);
    check("t7_pc", 64'(a16), 64'd2);
    check("t7_halted", 64'(h16), 64'd0);
    run(3, 0, c);
    check("t7_out", 64'(lastd[0]), 64'd9);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
